lbfgs_history_buf: RTL

- Circular history store for the last NUM_LOOP L-BFGS correction pairs (s_k, y_k, rho_k).
- Sits directly upstream of the search-direction unit (SDU) and feeds its s, y, rho and num_loop_current inputs.
- Serves each stream in two-loop order: newest→oldest for loop 1, then oldest→newest for loop 2.
- Each stream advances only on its own read-enable pulse from the SDU.

---
 rtl/lbfgs_history_buf.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lbfgs_history_buf.sv
// Circular store of the last NUM_LOOP L-BFGS (s, y, rho) pairs, replayed newest->oldest
// then oldest->newest on three independently paced read streams for the SDU.
module lbfgs_history_buf #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_ELEMENTS = 50,
  parameter int NUM_LOOP     = 10
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     wr_en,
  input  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  s_in,
  input  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  y_in,
  input  logic [DATA_WIDTH-1:0]                    rho_in,
  input  logic                                     flush,
  input  logic                                     start,
  input  logic                                     s_rd_en,
  input  logic                                     y_rd_en,
  input  logic                                     rho_rd_en,
  output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  s,
  output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  y,
  output logic [DATA_WIDTH-1:0]                    rho,
  output logic [$clog2(NUM_LOOP+1)-1:0]            num_loop_current,
  output logic                                     busy,
  output logic                                     wr_drop
);

  localparam int IW = (NUM_LOOP > 1) ? $clog2(NUM_LOOP) : 1;
  localparam int CW = $clog2(NUM_LOOP + 1);
  localparam int PW = $clog2(2 * NUM_LOOP + 1);
  localparam int AW = PW + 1;
  localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_LOOP - 1);
  localparam logic [CW-1:0] FULL      = CW'(NUM_LOOP);
  localparam logic [AW-1:0] DEPTH     = AW'(NUM_LOOP);

  typedef logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] vec_t;
  typedef enum logic {IDLE, READ} state_t;

  vec_t                  s_mem   [NUM_LOOP];
  vec_t                  y_mem   [NUM_LOOP];
  logic [DATA_WIDTH-1:0] rho_mem [NUM_LOOP];

  state_t        state;
  logic [IW-1:0] wr_ptr, newest, oldest, start_newest, start_oldest;
  logic [CW-1:0] count, n_seq;
  logic [PW-1:0] s_pos, y_pos, rho_pos;
  logic [IW-1:0] s_idx, y_idx, rho_idx;
  logic [AW-1:0] two_n, oldest_sum;
  logic          accept_wr, accept_start, s_adv, y_adv, rho_adv, all_done;

  // Sequence position -> slot: first half walks back from newest, second half forward from oldest.
  function automatic logic [IW-1:0] seq_index(input logic [PW-1:0] pos,
                                              input logic [IW-1:0] nw,
                                              input logic [IW-1:0] od,
                                              input logic [CW-1:0] n);
    logic [AW-1:0] p;
    logic [AW-1:0] t;
    p = AW'(pos);
    if (p < AW'(n)) begin
      t = (AW'(nw) >= p) ? AW'(nw) - p : AW'(nw) + DEPTH - p;
    end else begin
      t = AW'(od) + (p - AW'(n));
      if (t >= DEPTH) t = t - DEPTH;
    end
    return IW'(t);
  endfunction

  assign accept_wr    = wr_en && (state == IDLE) && !flush;
  assign accept_start = start && (state == IDLE) && !flush && (count != '0);
  assign two_n        = AW'({n_seq, 1'b0});
  assign s_adv        = s_rd_en   && (state == READ) && (AW'(s_pos)   != two_n);
  assign y_adv        = y_rd_en   && (state == READ) && (AW'(y_pos)   != two_n);
  assign rho_adv      = rho_rd_en && (state == READ) && (AW'(rho_pos) != two_n);
  assign all_done     = (AW'(s_pos) == two_n) && (AW'(y_pos) == two_n) && (AW'(rho_pos) == two_n);
  assign s_idx        = seq_index(s_pos, newest, oldest, n_seq);
  assign y_idx        = seq_index(y_pos, newest, oldest, n_seq);
  assign rho_idx      = seq_index(rho_pos, newest, oldest, n_seq);
  assign busy             = (state == READ);
  assign num_loop_current = count;

  // Oldest valid slot is wr_ptr - count (mod NUM_LOOP), i.e. newest - count + 1.
  always_comb begin
    start_newest = (wr_ptr == '0) ? LAST_SLOT : wr_ptr - 1'b1;
    oldest_sum   = (AW'(wr_ptr) >= AW'(count)) ? AW'(wr_ptr) - AW'(count)
                                               : AW'(wr_ptr) + DEPTH - AW'(count);
    start_oldest = IW'(oldest_sum);
  end

  always_ff @(posedge clk) begin
    if (accept_wr) begin
      s_mem[wr_ptr]   <= s_in;
      y_mem[wr_ptr]   <= y_in;
      rho_mem[wr_ptr] <= rho_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE; wr_ptr <= '0; count <= '0; wr_drop <= 1'b0;
      newest <= '0; oldest <= '0; n_seq <= '0;
      s_pos <= '0; y_pos <= '0; rho_pos <= '0;
    end else if (flush) begin
      state <= IDLE; wr_ptr <= '0; count <= '0; wr_drop <= 1'b0;
      newest <= '0; oldest <= '0; n_seq <= '0;
      s_pos <= '0; y_pos <= '0; rho_pos <= '0;
    end else begin
      wr_drop <= wr_en && (state == READ);
      if (accept_wr) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
        if (count != FULL) count <= count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept_start) begin
            newest  <= start_newest;
            oldest  <= start_oldest;
            n_seq   <= count;
            s_pos   <= '0;
            y_pos   <= '0;
            rho_pos <= '0;
            state   <= READ;
          end
        end
        READ: begin
          if (s_adv)   s_pos   <= s_pos + 1'b1;
          if (y_adv)   y_pos   <= y_pos + 1'b1;
          if (rho_adv) rho_pos <= rho_pos + 1'b1;
          if (all_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= '0; y <= '0; rho <= '0;
    end else if (flush) begin
      s <= '0; y <= '0; rho <= '0;
    end else begin
      if (s_adv)   s   <= s_mem[s_idx];
      if (y_adv)   y   <= y_mem[y_idx];
      if (rho_adv) rho <= rho_mem[rho_idx];
    end
  end

endmodule
